// File: rtl/quadrature_decoder.sv
// quadrature_decoder
//   Turns a two-phase incremental encoder signal pair (A/B) plus index pulse
//   into a wrap-around up/down position count. Raw pins are synchronised,
//   A/B are jointly glitch-filtered, and transitions are decoded into steps.
//   Transitions that change both phases at once are flagged as illegal.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   a_in, b_in   raw encoder phases (asynchronous to clk)
//   idx_in       raw encoder index pulse (asynchronous to clk)
//   enable       1 = position counts, 0 = position holds
//   clear        synchronous clear of position (highest priority after rst)
//   err_clear    synchronous clear of error_sticky
//   position     current position count, modulo 2^WIDTH
//   step_valid   one-cycle pulse when position stepped
//   step_dir     direction of the last applied step (1 = up, 0 = down)
//   illegal      one-cycle pulse on an illegal A/B transition
//   error_sticky latched illegal-transition flag
module quadrature_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             idx_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             err_clear,
  output logic [WIDTH-1:0] position,
  output logic             step_valid,
  output logic             step_dir,
  output logic             illegal,
  output logic             error_sticky
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [SYNC_STAGES-1:0] idx_sync;

  logic [1:0]    sync_ab;
  logic [1:0]    sync_ab_prev;
  logic [1:0]    filt_ab;
  logic [CW-1:0] filt_cnt;
  logic          idx_s;
  logic          idx_prev;
  logic          init;

  logic stable_change;
  logic commit;
  logic is_up;
  logic is_down;
  logic is_illegal;
  logic idx_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync   <= '0;
      b_sync   <= '0;
      idx_sync <= '0;
    end else begin
      a_sync   <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync   <= {b_sync[SYNC_STAGES-2:0], b_in};
      idx_sync <= {idx_sync[SYNC_STAGES-2:0], idx_in};
    end
  end

  assign sync_ab  = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign idx_s    = idx_sync[SYNC_STAGES-1];
  assign idx_rise = idx_s & ~idx_prev;

  // The transition is decoded from (filt_ab -> sync_ab) on the same edge the
  // filter accepts the new value, so position moves together with filt_ab
  // rather than a cycle after it.
  always_comb begin
    stable_change = (sync_ab != filt_ab) && (sync_ab == sync_ab_prev);
    commit        = stable_change && (filt_cnt == CNT_LAST);
    is_up         = 1'b0;
    is_down       = 1'b0;
    is_illegal    = 1'b0;
    if (commit && !init) begin
      case ({filt_ab, sync_ab})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: is_up   = 1'b1;
        4'b1000, 4'b1110, 4'b0111, 4'b0001: is_down = 1'b1;
        default:                            is_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ab_prev <= '0;
      filt_ab      <= '0;
      filt_cnt     <= '0;
      idx_prev     <= 1'b0;
      init         <= 1'b1;
    end else begin
      sync_ab_prev <= sync_ab;
      idx_prev     <= idx_s;
      if (stable_change) begin
        if (commit) begin
          filt_ab  <= sync_ab;
          filt_cnt <= '0;
          init     <= 1'b0;
        end else begin
          filt_cnt <= filt_cnt + CW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position     <= '0;
      step_valid   <= 1'b0;
      step_dir     <= 1'b0;
      illegal      <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      illegal    <= is_illegal;
      if (clear) begin
        position <= '0;
      end else if (enable && idx_rise) begin
        position <= '0;
      end else if (enable && (is_up || is_down)) begin
        position   <= is_up ? position + ONE : position - ONE;
        step_valid <= 1'b1;
        step_dir   <= is_up;
      end
      if (is_illegal) begin
        error_sticky <= 1'b1;
      end else if (err_clear) begin
        error_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in, idx_in;
  logic       enable, clear, err_clear;
  logic [7:0] position;
  logic       step_valid, step_dir, illegal, error_sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  // step events: {dir, position}; illegal events: position
  logic [8:0] step_q[$];
  logic [7:0] ill_q[$];

  quadrature_decoder #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .enable(enable), .clear(clear), .err_clear(err_clear),
    .position(position), .step_valid(step_valid), .step_dir(step_dir),
    .illegal(illegal), .error_sticky(error_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Drive A/B and hold 8 clocks; optionally expect one step event.
  task automatic step_to(input logic [1:0] ab, input bit do_push, input logic [8:0] exp);
    @(negedge clk);
    a_in = ab[1];
    b_in = ab[0];
    if (do_push) step_q.push_back(exp);
    repeat (8) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic pulse_err_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  // Monitor: pops an expectation each time the DUT presents an event.
  initial begin
    logic [8:0] e;
    logic [7:0] ep;
    forever begin
      @(posedge clk);
      #1;
      if (step_valid) begin
        if (step_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_step: got dir=%0b pos=%0h expected none at %0t",
                   step_dir, position, $time);
        end else begin
          e = step_q.pop_front();
          check("step_dir", 32'(step_dir), 32'(e[8]));
          check("step_pos", 32'(position), 32'(e[7:0]));
        end
      end
      if (illegal) begin
        if (ill_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_illegal: got pulse expected none at %0t", $time);
        end else begin
          ep = ill_q.pop_front();
          check("illegal_pos", 32'(position), 32'(ep));
          check("illegal_sticky", 32'(error_sticky), 32'(1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cur;
    int k;
    rst = 1'b1; a_in = 0; b_in = 0; idx_in = 0;
    enable = 1'b1; clear = 0; err_clear = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_position", 32'(position), 32'h0);
    check("rst_step_valid", 32'(step_valid), 32'h0);
    check("rst_step_dir", 32'(step_dir), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_sticky", 32'(error_sticky), 32'h0);
    @(negedge clk); rst = 1'b0;

    // First filtered change only consumes the init flag.
    step_to(2'b10, 0, '0);
    check("init_no_step", 32'(position), 32'h0);
    step_to(2'b00, 1, {1'b0, 8'hFF});
    check("prime_wrap_down", 32'(position), 32'hFF);
    pulse_clear();
    check("clear_pos", 32'(position), 32'h0);

    // Four forward cycles; latency measured on the first A edge.
    @(negedge clk);
    a_in = 1'b1;
    step_q.push_back({1'b1, 8'd1});
    k = 0;
    while (k < 12) begin
      @(posedge clk);
      k++;
      #1;
      if (step_valid) break;
    end
    check("first_step_latency", 32'(k), 32'd6);
    repeat (4) @(posedge clk);
    cur = 2'b10;
    for (int i = 1; i < 16; i++) begin
      cur = next_fwd(cur);
      step_to(cur, 1, {1'b1, 8'(i + 1)});
    end
    check("fwd_16", 32'(position), 32'd16);
    check("fwd_dir", 32'(step_dir), 32'd1);

    // Wrap both ways from 0.
    pulse_clear();
    step_to(2'b01, 1, {1'b0, 8'hFF});
    check("rev_wrap", 32'(position), 32'hFF);
    step_to(2'b00, 1, {1'b1, 8'h00});
    check("fwd_wrap", 32'(position), 32'h00);

    // 2-clock glitch on A is rejected.
    @(negedge clk); a_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); a_in = 1'b0;
    repeat (10) @(posedge clk);
    check("glitch_pos", 32'(position), 32'h0);
    check("glitch_sticky", 32'(error_sticky), 32'h0);

    // Illegal jump 00->11.
    ill_q.push_back(8'h00);
    step_to(2'b11, 0, '0);
    check("illegal_sticky_set", 32'(error_sticky), 32'h1);
    check("illegal_pos_hold", 32'(position), 32'h0);
    pulse_err_clear();
    check("err_clear", 32'(error_sticky), 32'h0);
    // Illegal 11->00 with err_clear on the same edge: set wins.
    @(negedge clk); a_in = 0; b_in = 0;
    ill_q.push_back(8'h00);
    repeat (5) @(posedge clk);
    @(negedge clk); err_clear = 1'b1;
    @(posedge clk);
    #1;
    check("set_wins_pulse", 32'(illegal), 32'h1);
    check("set_wins_sticky", 32'(error_sticky), 32'h1);
    @(negedge clk); err_clear = 1'b0;
    repeat (3) @(posedge clk);
    check("set_wins_hold", 32'(error_sticky), 32'h1);

    // Inputs parked at 11 through reset: no false illegal.
    @(negedge clk); rst = 1'b1; a_in = 1; b_in = 1;
    #1;
    check("midrst_pos", 32'(position), 32'h0);
    check("midrst_sticky", 32'(error_sticky), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    check("park11_sticky", 32'(error_sticky), 32'h0);
    step_to(2'b01, 1, {1'b1, 8'd1});
    check("park11_up", 32'(position), 32'd1);

    // Climb to 37.
    cur = 2'b01;
    for (int i = 0; i < 36; i++) begin
      cur = next_fwd(cur);
      step_to(cur, 1, {1'b1, 8'(i + 2)});
    end
    check("pos_37", 32'(position), 32'd37);

    // enable = 0: position holds, no burst on re-enable.
    @(negedge clk); enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cur = next_fwd(cur);
      step_to(cur, 0, '0);
    end
    check("disabled_hold", 32'(position), 32'd37);
    @(negedge clk); enable = 1'b1;
    repeat (6) @(posedge clk);
    check("reenable_no_burst", 32'(position), 32'd37);

    // Index pulse zeroes position.
    @(negedge clk); idx_in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); idx_in = 1'b0;
    repeat (4) @(posedge clk);
    check("index_zero", 32'(position), 32'd0);
    cur = next_fwd(cur); step_to(cur, 1, {1'b1, 8'd1});
    cur = next_fwd(cur); step_to(cur, 1, {1'b1, 8'd2});
    check("post_index", 32'(position), 32'd2);

    // clear coincident with a step.
    cur = next_fwd(cur);
    @(negedge clk); a_in = cur[1]; b_in = cur[0];
    repeat (5) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_step_valid", 32'(step_valid), 32'h0);
    check("clear_step_pos", 32'(position), 32'h0);
    @(negedge clk); clear = 1'b0;
    repeat (6) @(posedge clk);
    check("clear_step_hold", 32'(position), 32'h0);

    repeat (10) @(posedge clk);
    check("step_q_drained", 32'(step_q.size()), 32'd0);
    check("ill_q_drained", 32'(ill_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
